// File: rtl/spatz_pkg.sv
// Shared VRF definitions: default geometry, word/address/byte-enable types and
// the fixed requester port indices for the VFU, VLSU and slide unit.
// No logic; latency and backpressure are properties of the modules that use it.
package spatz_pkg;

    // Default VRF geometry
    localparam int unsigned VrfNrReadPorts  = 5;
    localparam int unsigned VrfNrWritePorts = 3;
    localparam int unsigned VrfNrBanks      = 4;
    localparam int unsigned VrfNrVRegs      = 32;
    localparam int unsigned VrfElemPerReg   = 8;
    localparam int unsigned VrfWordWidth    = 64;
    localparam int unsigned VrfAddrWidth    = $clog2(VrfNrVRegs * VrfElemPerReg);

    // Word address is {vreg, elem}
    typedef logic [VrfAddrWidth-1:0]   vrf_addr_t;
    typedef logic [VrfWordWidth-1:0]   vrf_data_t;
    typedef logic [VrfWordWidth/8-1:0] vrf_be_t;

    // Read port indices
    localparam int unsigned VFU_RD_A = 0;
    localparam int unsigned VFU_RD_B = 1;
    localparam int unsigned VFU_RD_C = 2;
    localparam int unsigned VLSU_RD  = 3;
    localparam int unsigned VSLD_RD  = 4;

    // Write port indices; lower index = higher static priority
    localparam int unsigned VFU_WR  = 0;
    localparam int unsigned VLSU_WR = 1;
    localparam int unsigned VSLD_WR = 2;

endpackage

// File: rtl/spatz_vrf_bank.sv
// One VRF bank: flop storage, one-write-per-cycle arbiter with stall aging, N-of-M round-robin read arbiter.
// Latency: grants combinational; write lands at the clock edge; read word is combinational (registered by the top).
// Backpressure: denied requesters must hold their request; nothing is queued here.
// Ports: clk_i/rst_i; wreq_i/wrow_i/wdata_i/wbe_i -> wgnt_o; rreq_i/rrow_i -> rgnt_o, rdata_o (per read port).
module spatz_vrf_bank #(
    parameter int unsigned NrReadPorts        = 5,
    parameter int unsigned NrWritePorts       = 3,
    parameter int unsigned NrReadPortsPerBank = 3,
    parameter int unsigned NrRows             = 64,
    parameter int unsigned RowWidth           = 6,
    parameter int unsigned WordWidth          = 64,
    parameter int unsigned MaxStall           = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrWritePorts-1:0]             wreq_i,
    input  logic [NrWritePorts*RowWidth-1:0]    wrow_i,
    input  logic [NrWritePorts*WordWidth-1:0]   wdata_i,
    input  logic [NrWritePorts*WordWidth/8-1:0] wbe_i,
    output logic [NrWritePorts-1:0]             wgnt_o,
    input  logic [NrReadPorts-1:0]              rreq_i,
    input  logic [NrReadPorts*RowWidth-1:0]     rrow_i,
    output logic [NrReadPorts-1:0]              rgnt_o,
    output logic [NrReadPorts*WordWidth-1:0]    rdata_o
);

    localparam int unsigned BeWidth   = WordWidth / 8;
    localparam int unsigned WIdxWidth = (NrWritePorts > 1) ? $clog2(NrWritePorts) : 1;
    localparam int unsigned PtrWidth  = (NrReadPorts > 1) ? $clog2(NrReadPorts) : 1;
    localparam int unsigned CntWidth  = $clog2(MaxStall + 1);
    localparam logic [CntWidth-1:0] StallMax = CntWidth'(MaxStall);

    logic [WordWidth-1:0] mem_q [NrRows];

    // ------------------------------------------------------------------
    // Write arbitration: any aged requester beats static priority
    // ------------------------------------------------------------------
    logic [CntWidth-1:0]  stall_q [NrWritePorts];
    logic [CntWidth-1:0]  stall_d [NrWritePorts];
    logic [WIdxWidth-1:0] widx;
    logic                 wfound;

    always_comb begin
        wfound = 1'b0;
        widx   = '0;
        for (int p = 0; p < NrWritePorts; p++) begin
            if (!wfound && wreq_i[p] && (stall_q[p] == StallMax)) begin
                wfound = 1'b1;
                widx   = WIdxWidth'(p);
            end
        end
        for (int p = 0; p < NrWritePorts; p++) begin
            if (!wfound && wreq_i[p]) begin
                wfound = 1'b1;
                widx   = WIdxWidth'(p);
            end
        end
        wgnt_o = '0;
        if (wfound) wgnt_o[widx] = 1'b1;
    end

    // Counter only runs while the port keeps asking this bank and loses
    always_comb begin
        for (int p = 0; p < NrWritePorts; p++) begin
            stall_d[p] = stall_q[p];
            if (!wreq_i[p] || wgnt_o[p]) begin
                stall_d[p] = '0;
            end else if (stall_q[p] != StallMax) begin
                stall_d[p] = stall_q[p] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NrWritePorts; p++) stall_q[p] <= '0;
        end else begin
            for (int p = 0; p < NrWritePorts; p++) stall_q[p] <= stall_d[p];
        end
    end

    // ------------------------------------------------------------------
    // Storage write under byte enables (all-zero enables: granted, no change)
    // ------------------------------------------------------------------
    logic [RowWidth-1:0]  wrow_sel;
    logic [WordWidth-1:0] wdata_sel;
    logic [BeWidth-1:0]   wbe_sel;

    assign wrow_sel  = wrow_i[widx*RowWidth +: RowWidth];
    assign wdata_sel = wdata_i[widx*WordWidth +: WordWidth];
    assign wbe_sel   = wbe_i[widx*BeWidth +: BeWidth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NrRows; r++) mem_q[r] <= '0;
        end else if (wfound) begin
            for (int j = 0; j < BeWidth; j++) begin
                if (wbe_sel[j]) mem_q[wrow_sel][j*8 +: 8] <= wdata_sel[j*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read arbitration: scan from the pointer, grant up to NrReadPortsPerBank,
    // pointer moves to one past the last port granted
    // ------------------------------------------------------------------
    logic [PtrWidth-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin : p_read_rr
        int   idx;
        int   ngnt;
        int   last;
        logic any;
        rgnt_o = '0;
        idx    = 0;
        ngnt   = 0;
        last   = 0;
        any    = 1'b0;
        for (int i = 0; i < NrReadPorts; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= int'(NrReadPorts)) idx = idx - int'(NrReadPorts);
            if (rreq_i[idx] && (ngnt < int'(NrReadPortsPerBank))) begin
                rgnt_o[idx] = 1'b1;
                ngnt        = ngnt + 1;
                last        = idx;
                any         = 1'b1;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (any) rr_ptr_d = (last == int'(NrReadPorts) - 1) ? '0 : PtrWidth'(last + 1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end

    // Pre-write storage contents: a same-cycle write is not forwarded
    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NrReadPorts; p++) begin
            rdata_o[p*WordWidth +: WordWidth] = mem_q[rrow_i[p*RowWidth +: RowWidth]];
        end
    end

endmodule

// File: rtl/spatz_banked_vrf.sv
// Banked vector register file: word addresses {vreg, elem} striped across banks by element index.
// Latency: wvalid_o/rgnt_o combinational in the request cycle; rdata_o/rvalid_o one cycle after rgnt_o.
// Backpressure: ungranted write/read requesters hold their request until accepted; no internal queue.
// Ports: clk_i, rst_i (async active-high); write side waddr_i/wdata_i/wbe_i/we_i -> wvalid_o;
//        read side raddr_i/re_i -> rgnt_o, then rdata_o/rvalid_o. All per-port buses are flat, port 0 in the LSBs.
module spatz_banked_vrf
    import spatz_pkg::*;
#(
    parameter int unsigned NrReadPorts        = VrfNrReadPorts,
    parameter int unsigned NrWritePorts       = VrfNrWritePorts,
    parameter int unsigned NrBanks            = VrfNrBanks,
    parameter int unsigned NrReadPortsPerBank = 3,
    parameter int unsigned NrVRegs            = VrfNrVRegs,
    parameter int unsigned ElemPerReg         = VrfElemPerReg,
    parameter int unsigned WordWidth          = VrfWordWidth,
    parameter int unsigned MaxStall           = 3,
    localparam int unsigned AddrWidth         = $clog2(NrVRegs * ElemPerReg)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NrWritePorts*AddrWidth-1:0]   waddr_i,
    input  logic [NrWritePorts*WordWidth-1:0]   wdata_i,
    input  logic [NrWritePorts*WordWidth/8-1:0] wbe_i,
    input  logic [NrWritePorts-1:0]             we_i,
    output logic [NrWritePorts-1:0]             wvalid_o,
    input  logic [NrReadPorts*AddrWidth-1:0]    raddr_i,
    input  logic [NrReadPorts-1:0]              re_i,
    output logic [NrReadPorts-1:0]              rgnt_o,
    output logic [NrReadPorts*WordWidth-1:0]    rdata_o,
    output logic [NrReadPorts-1:0]              rvalid_o
);

    // Bank = low elem bits; row = everything above them, which equals
    // vreg*(ElemPerReg/NrBanks) + elem/NrBanks because the address is {vreg, elem}.
    localparam int unsigned BankWidth = $clog2(NrBanks);
    localparam int unsigned RowWidth  = AddrWidth - BankWidth;
    localparam int unsigned NrRows    = (NrVRegs * ElemPerReg) / NrBanks;

    logic [BankWidth-1:0]              wbank [NrWritePorts];
    logic [BankWidth-1:0]              rbank [NrReadPorts];
    logic [NrWritePorts*RowWidth-1:0]  wrow;
    logic [NrReadPorts*RowWidth-1:0]   rrow;

    logic [NrWritePorts-1:0]           bank_wreq  [NrBanks];
    logic [NrWritePorts-1:0]           bank_wgnt  [NrBanks];
    logic [NrReadPorts-1:0]            bank_rreq  [NrBanks];
    logic [NrReadPorts-1:0]            bank_rgnt  [NrBanks];
    logic [NrReadPorts*WordWidth-1:0]  bank_rdata [NrBanks];

    logic [NrWritePorts-1:0]           wgnt_all;
    logic [NrReadPorts-1:0]            rgnt_all;
    logic [NrReadPorts*WordWidth-1:0]  rword;

    logic [NrReadPorts-1:0]            rvalid_q;
    logic [NrReadPorts*WordWidth-1:0]  rdata_q, rdata_d;

    // Address decode and per-bank request steering
    always_comb begin
        wrow = '0;
        rrow = '0;
        for (int p = 0; p < NrWritePorts; p++) begin
            wbank[p]                   = waddr_i[p*AddrWidth +: BankWidth];
            wrow[p*RowWidth +: RowWidth] = waddr_i[p*AddrWidth + BankWidth +: RowWidth];
        end
        for (int p = 0; p < NrReadPorts; p++) begin
            rbank[p]                   = raddr_i[p*AddrWidth +: BankWidth];
            rrow[p*RowWidth +: RowWidth] = raddr_i[p*AddrWidth + BankWidth +: RowWidth];
        end
        for (int b = 0; b < NrBanks; b++) begin
            for (int p = 0; p < NrWritePorts; p++) begin
                bank_wreq[b][p] = we_i[p] && (wbank[p] == BankWidth'(b));
            end
            for (int p = 0; p < NrReadPorts; p++) begin
                bank_rreq[b][p] = re_i[p] && (rbank[p] == BankWidth'(b));
            end
        end
    end

    for (genvar b = 0; b < NrBanks; b++) begin : g_bank
        spatz_vrf_bank #(
            .NrReadPorts        (NrReadPorts),
            .NrWritePorts       (NrWritePorts),
            .NrReadPortsPerBank (NrReadPortsPerBank),
            .NrRows             (NrRows),
            .RowWidth           (RowWidth),
            .WordWidth          (WordWidth),
            .MaxStall           (MaxStall)
        ) i_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .wreq_i  (bank_wreq[b]),
            .wrow_i  (wrow),
            .wdata_i (wdata_i),
            .wbe_i   (wbe_i),
            .wgnt_o  (bank_wgnt[b]),
            .rreq_i  (bank_rreq[b]),
            .rrow_i  (rrow),
            .rgnt_o  (bank_rgnt[b]),
            .rdata_o (bank_rdata[b])
        );
    end

    // Each port talks to exactly one bank, so OR-ing the bank grants is exact
    always_comb begin
        wgnt_all = '0;
        rgnt_all = '0;
        rword    = '0;
        for (int b = 0; b < NrBanks; b++) begin
            wgnt_all = wgnt_all | bank_wgnt[b];
            rgnt_all = rgnt_all | bank_rgnt[b];
        end
        for (int p = 0; p < NrReadPorts; p++) begin
            rword[p*WordWidth +: WordWidth] = bank_rdata[rbank[p]][p*WordWidth +: WordWidth];
        end
    end

    // Grants are suppressed during reset so nothing is accepted or launched
    assign wvalid_o = rst_i ? '0 : wgnt_all;
    assign rgnt_o   = rst_i ? '0 : rgnt_all;

    // Read data only updates on a grant; otherwise it holds the last value
    always_comb begin
        rdata_d = rdata_q;
        for (int p = 0; p < NrReadPorts; p++) begin
            if (rgnt_all[p]) rdata_d[p*WordWidth +: WordWidth] = rword[p*WordWidth +: WordWidth];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rgnt_all;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_spatz_banked_vrf.sv
// Directed self-checking bench for spatz_banked_vrf at default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Address map used below: addr = {vreg[4:0], elem[2:0]}, bank = elem[1:0].
module tb_spatz_banked_vrf;
    import spatz_pkg::*;

    localparam int NR = 5;
    localparam int NW = 3;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int BW = 8;

    logic                clk_i;
    logic                rst_i;
    logic [NW*AW-1:0]    waddr_i;
    logic [NW*DW-1:0]    wdata_i;
    logic [NW*BW-1:0]    wbe_i;
    logic [NW-1:0]       we_i;
    logic [NW-1:0]       wvalid_o;
    logic [NR*AW-1:0]    raddr_i;
    logic [NR-1:0]       re_i;
    logic [NR-1:0]       rgnt_o;
    logic [NR*DW-1:0]    rdata_o;
    logic [NR-1:0]       rvalid_o;

    int n_checks = 0;
    int n_fail   = 0;

    spatz_banked_vrf dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .wbe_i    (wbe_i),
        .we_i     (we_i),
        .wvalid_o (wvalid_o),
        .raddr_i  (raddr_i),
        .re_i     (re_i),
        .rgnt_o   (rgnt_o),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        we_i    = '0;
        re_i    = '0;
        waddr_i = '0;
        wdata_i = '0;
        wbe_i   = '0;
        raddr_i = '0;
    endtask

    task automatic set_w(input int p, input vrf_addr_t a, input vrf_data_t d, input vrf_be_t be);
        we_i[p]              = 1'b1;
        waddr_i[p*AW +: AW]  = a;
        wdata_i[p*DW +: DW]  = d;
        wbe_i[p*BW +: BW]    = be;
    endtask

    task automatic set_r(input int p, input vrf_addr_t a);
        re_i[p]             = 1'b1;
        raddr_i[p*AW +: AW] = a;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    logic [2:0] exp_age [5] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b001};

    initial begin
        clear_inputs();
        rst_i = 1'b1;
        // Requests during reset must not be accepted
        set_w(0, 8'h08, 64'h1, 8'hFF);
        set_r(0, 8'h08);
        repeat (2) @(negedge clk_i);
        check("rst_wvalid", 64'(wvalid_o), 64'h0);
        check("rst_rgnt",   64'(rgnt_o),   64'h0);
        check("rst_rvalid", 64'(rvalid_o), 64'h0);
        for (int p = 0; p < NR; p++) check($sformatf("rst_rdata%0d", p), rdata_o[p*DW +: DW], 64'h0);

        step();
        clear_inputs();
        rst_i = 1'b0;

        // Five readers on bank 0: 0,1,2 first, then 3,4,0
        for (int p = 0; p < NR; p++) set_r(p, vrf_addr_t'(p * 4));
        @(negedge clk_i);
        check("rr_cycle1_rgnt", 64'(rgnt_o), 64'h07);
        @(negedge clk_i);
        check("rr_cycle2_rgnt", 64'(rgnt_o), 64'h19);
        check("rr_cycle2_rvalid", 64'(rvalid_o), 64'h07);
        check("rr_rdata0_zero", rdata_o[0*DW +: DW], 64'h0);
        step();
        clear_inputs();
        @(negedge clk_i);
        check("rr_cycle3_rvalid", 64'(rvalid_o), 64'h19);

        // Write v1.e0 from port 0, read back on port 3
        step();
        clear_inputs();
        set_w(0, 8'h08, 64'hA5A5, 8'hFF);
        @(negedge clk_i);
        check("wr_v1e0_wvalid", 64'(wvalid_o), 64'h1);
        step();
        clear_inputs();
        set_r(3, 8'h08);
        @(negedge clk_i);
        check("rd_v1e0_rgnt", 64'(rgnt_o), 64'h08);
        step();
        clear_inputs();
        @(negedge clk_i);
        check("rd_v1e0_rvalid", 64'(rvalid_o), 64'h08);
        check("rd_v1e0_rdata", rdata_o[3*DW +: DW], 64'hA5A5);
        @(negedge clk_i);
        check("rd_idle_rvalid", 64'(rvalid_o), 64'h0);
        check("rd_hold_rdata", rdata_o[3*DW +: DW], 64'hA5A5);

        // Ports 0 and 2 fight for bank 0; port 2 ages after 3 denials
        step();
        clear_inputs();
        set_w(0, 8'h10, 64'h11, 8'hFF);
        set_w(2, 8'h18, 64'h22, 8'hFF);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check($sformatf("age_cycle%0d_wvalid", c), 64'(wvalid_o), 64'(exp_age[c]));
        end
        step();
        clear_inputs();
        set_r(1, 8'h10);
        set_r(2, 8'h18);
        @(negedge clk_i);
        check("age_rd_rgnt", 64'(rgnt_o), 64'h06);
        step();
        clear_inputs();
        @(negedge clk_i);
        check("age_rd_port0_data", rdata_o[1*DW +: DW], 64'h11);
        check("age_rd_port2_data", rdata_o[2*DW +: DW], 64'h22);

        // Same-cycle read and write of v2.e1: old value, then new value
        step();
        clear_inputs();
        set_w(0, 8'h11, 64'h1, 8'hFF);
        set_r(0, 8'h11);
        @(negedge clk_i);
        check("rw_same_wvalid", 64'(wvalid_o), 64'h1);
        check("rw_same_rgnt", 64'(rgnt_o), 64'h01);
        step();
        clear_inputs();
        set_r(0, 8'h11);
        @(negedge clk_i);
        check("rw_same_rvalid", 64'(rvalid_o), 64'h01);
        check("rw_same_prewrite", rdata_o[0*DW +: DW], 64'h0);
        step();
        clear_inputs();
        @(negedge clk_i);
        check("rw_reread", rdata_o[0*DW +: DW], 64'h1);

        // Partial byte enables, then an all-zero-enable write
        step();
        clear_inputs();
        set_w(1, 8'h22, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        @(negedge clk_i);
        check("be_full_wvalid", 64'(wvalid_o), 64'h2);
        step();
        clear_inputs();
        set_w(1, 8'h22, 64'h0, 8'h0F);
        @(negedge clk_i);
        check("be_low_wvalid", 64'(wvalid_o), 64'h2);
        step();
        clear_inputs();
        set_w(2, 8'h22, 64'h1234, 8'h00);
        @(negedge clk_i);
        check("be_zero_wvalid", 64'(wvalid_o), 64'h4);
        step();
        clear_inputs();
        set_r(4, 8'h22);
        @(negedge clk_i);
        check("be_rd_rgnt", 64'(rgnt_o), 64'h10);
        step();
        clear_inputs();
        @(negedge clk_i);
        check("be_rd_data", rdata_o[4*DW +: DW], 64'hFFFF_FFFF_0000_0000);

        // Asynchronous reset right after a read grant
        step();
        clear_inputs();
        set_r(1, 8'h08);
        @(negedge clk_i);
        check("arst_pre_rgnt", 64'(rgnt_o), 64'h02);
        step();
        clear_inputs();
        #1;
        check("arst_pre_rvalid", 64'(rvalid_o), 64'h02);
        check("arst_pre_rdata", rdata_o[1*DW +: DW], 64'hA5A5);
        set_r(1, 8'h08);
        rst_i = 1'b1;
        #1;
        check("arst_rvalid", 64'(rvalid_o), 64'h0);
        check("arst_rdata", rdata_o[1*DW +: DW], 64'h0);
        check("arst_rgnt", 64'(rgnt_o), 64'h0);
        step();
        clear_inputs();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("arst_post_rvalid", 64'(rvalid_o), 64'h0);
        step();
        set_r(1, 8'h08);
        @(negedge clk_i);
        check("arst_rd_rgnt", 64'(rgnt_o), 64'h02);
        step();
        clear_inputs();
        @(negedge clk_i);
        check("arst_rd_rvalid", 64'(rvalid_o), 64'h02);
        check("arst_rd_cleared", rdata_o[1*DW +: DW], 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spatz_banked_vrf.md
SPATZ_BANKED_VRF -- requirements
Module: spatz_banked_vrf

Interface
REQ-001 SHALL have parameter NrReadPorts, default 5: number of requester read ports.
REQ-002 SHALL have parameter NrWritePorts, default 3: number of requester write ports; index 0 is highest static priority.
REQ-003 SHALL have parameter NrBanks, default 4, power of two: number of storage banks.
REQ-004 SHALL have parameter NrReadPortsPerBank, default 3: read grants per bank per cycle.
REQ-005 SHALL have parameter NrVRegs, default 32: architectural vector registers.
REQ-006 SHALL have parameter ElemPerReg, default 8, power of two and at least NrBanks: words per register.
REQ-007 SHALL have parameter WordWidth, default 64: bits per word.
REQ-008 SHALL have parameter MaxStall, default 3: consecutive denials before a write port is aged.
REQ-009 SHALL have clk_i  in  1: clock.
REQ-010 SHALL have rst_i  in  1: reset, asynchronous, active-high.
REQ-011 SHALL have waddr_i  in  NrWritePorts x log2(NrVRegs*ElemPerReg): word address {vreg, elem}.
REQ-012 SHALL have wdata_i  in  NrWritePorts x WordWidth: write data.
REQ-013 SHALL have wbe_i  in  NrWritePorts x WordWidth/8: byte enables.
REQ-014 SHALL have we_i  in  NrWritePorts: write request.
REQ-015 SHALL have wvalid_o  out  NrWritePorts: write accepted this cycle.
REQ-016 SHALL have raddr_i  in  NrReadPorts x address width: read word address.
REQ-017 SHALL have re_i  in  NrReadPorts: read request.
REQ-018 SHALL have rgnt_o  out  NrReadPorts: read accepted this cycle.
REQ-019 SHALL have rdata_o  out  NrReadPorts x WordWidth: registered read data.
REQ-020 SHALL have rvalid_o  out  NrReadPorts: rdata_o valid, one cycle after rgnt_o.

Function
REQ-021 SHALL map each address to bank = elem mod NrBanks and row = vreg*(ElemPerReg/NrBanks) + elem/NrBanks.
REQ-022 SHALL accept at most one write per bank per cycle; wvalid_o is combinational in the request cycle, and the write takes effect at that clock edge under wbe_i.
REQ-023 SHALL grant bank writes by static priority, lowest index first, except that an aged port wins; among several aged ports the lowest index wins.
REQ-024 SHALL keep one saturating stall counter per write port: it increments when we_i is high and wvalid_o is low, and clears on grant or when we_i drops; the port is aged when the counter reaches MaxStall.
REQ-025 SHALL grant up to NrReadPortsPerBank reads per bank per cycle, chosen round-robin; each bank keeps a pointer that advances to one past the last granted port.
REQ-026 SHALL return data for a read granted in cycle N on rdata_o with rvalid_o high in cycle N+1; rvalid_o is low and rdata_o holds its last value otherwise.
REQ-027 SHALL return pre-write data when a read and a write hit the same row in the same cycle; no forwarding.
REQ-028 SHALL expect ungranted requesters to hold their request; the block keeps no request queue.
REQ-029 SHALL keep wbe_i all-zero writes granted but leave storage unchanged.

Reset
REQ-030 SHALL, while rst_i is high, force wvalid_o, rgnt_o and rvalid_o to 0, rdata_o to 0, all stall counters and round-robin pointers to 0, and all storage to 0.
REQ-031 SHALL drop any read granted in the cycle reset asserts; no rvalid_o follows reset.

Structure
REQ-032 SHALL take the address, data and byte-enable typedefs and the port-index constants (VFU_*, VLSU_*, VSLD_*) from spatz_pkg.
REQ-033 SHALL instantiate one sub-module per bank, spatz_vrf_bank, holding flop storage, the write arbiter, stall counters and the read round-robin arbiter.

Verification
REQ-034 Write 0xA5A5 to v1.e0 from port 0, then read it from port 3 -> rgnt_o[3]=1, and one cycle later rvalid_o[3]=1 with rdata_o[3]=0xA5A5.
REQ-035 Ports 0 and 2 write the same bank continuously with MaxStall=3 -> port 2 is denied for 3 cycles, then granted in the 4th cycle while port 0 is denied once.
REQ-036 Five read ports target bank 0 in the same cycle with NrReadPortsPerBank=3 -> ports 0-2 granted; next cycle ports 3, 4 and 0 granted.
REQ-037 Write 0x1 and read 0x0-valued v2.e1 in the same cycle -> rdata_o returns 0x0; a re-read returns 0x1.
REQ-038 Write with wbe_i=0x0F over 0xFFFF_FFFF_FFFF_FFFF using data 0 -> read returns 0xFFFF_FFFF_0000_0000.
REQ-039 Assert rst_i asynchronously in the cycle after a read grant -> rvalid_o=0 immediately; a subsequent read returns 0.
